// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked data-port memory for the core's load/store path.
// Accepts one request at a time, waits WAIT cycles, performs a byte/half/word
// access with RISC-V funct3 sizing and returns load data or an error flag.
module data_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_size;
  logic [31:0] r_rd_word;
  logic [31:0] r_mem [DEPTH];

  logic          w_accept;
  logic          w_access;
  logic          w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_wr_data;
  logic [31:0]   w_ld_data;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [7:0]    w_lane [4];
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_acc_idx;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_access  = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_idx     = r_addr[AW+1:2];
  assign w_acc_idx = req_addr[AW+1:2];

  // Split the fetched word into its byte lanes for load extraction.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = r_rd_word[8*gi +: 8];
  end

  // Error decode: illegal size, store with unsigned size, misalignment, out of range.
  always_comb begin
    w_err = 1'b0;
    case (r_size)
      3'b000: w_err = 1'b0;
      3'b001: w_err = r_addr[0];
      3'b010: w_err = (r_addr[1:0] != 2'b00);
      3'b100: w_err = r_we;
      3'b101: w_err = r_we | r_addr[0];
      default: w_err = 1'b1;
    endcase
    // Word index past the array, including any nonzero address bits above it.
    if (r_addr[31:2] >= 30'(DEPTH)) begin
      w_err = 1'b1;
    end
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    w_be      = 4'b1111;
    w_wr_data = r_wdata;
    case (r_size[1:0])
      2'b00: begin
        w_be      = 4'b0001 << r_addr[1:0];
        w_wr_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be      = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wr_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be      = 4'b1111;
        w_wr_data = r_wdata;
      end
    endcase
  end

  // Load extraction with sign or zero extension.
  always_comb begin
    w_byte    = w_lane[r_addr[1:0]];
    w_half    = r_addr[1] ? r_rd_word[31:16] : r_rd_word[15:0];
    w_ld_data = 32'd0;
    case (r_size)
      3'b000: w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001: w_ld_data = {{16{w_half[15]}}, w_half};
      3'b010: w_ld_data = r_rd_word;
      3'b100: w_ld_data = {24'd0, w_byte};
      3'b101: w_ld_data = {16'd0, w_half};
      default: w_ld_data = 32'd0;
    endcase
  end

  // Array port: registered read at accept (only one transaction can be in
  // flight, so the word cannot change before the access), byte-lane write at access.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rd_word <= r_mem[w_acc_idx];
    end
    if (w_access && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_size    <= 3'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_size    <= req_size;
            r_cnt     <= 4'(WAIT);
            req_ready <= 1'b0;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= w_err;
            rsp_rdata <= (w_err || r_we) ? 32'd0 : w_ld_data;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed cases followed by random traffic,
// checked against a byte-addressed reference memory.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WAIT  = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT(WAIT)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference memory, one entry per byte address.
  logic [7:0] m_mem [0:4*DEPTH-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic model_err(input logic we, input logic [31:0] addr, input logic [2:0] size);
    int nb;
    logic [31:0] lim;
    nb  = size_bytes(size);
    lim = 4 * DEPTH;
    if (nb == 0) return 1'b1;
    if (we && size[2]) return 1'b1;
    if (nb == 2 && addr[0]) return 1'b1;
    if (nb == 4 && addr[1:0] != 2'b00) return 1'b1;
    if (addr >= lim) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] v;
    int nb;
    v  = 32'd0;
    nb = size_bytes(size);
    for (int k = 0; k < nb; k++) begin
      v = v | (32'(m_mem[addr + 32'(k)]) << (8 * k));
    end
    if (size == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (size == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] size);
    int nb;
    nb = size_bytes(size);
    for (int k = 0; k < nb; k++) begin
      m_mem[addr + 32'(k)] = wdata[8*k +: 8];
    end
  endtask

  // One full transaction: request, latency check, optional response back-pressure, release.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] size, input int hold, input string tag);
    logic        exp_err;
    logic [31:0] exp_data;
    int          cycles;
    logic        got;
    exp_err  = model_err(we, addr, size);
    exp_data = (exp_err || we) ? 32'd0 : model_load(addr, size);
    if (!exp_err && we) model_store(addr, wdata, size);

    @(negedge clk);
    check({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cycles = 0;
    got    = 1'b0;
    while (cycles < 40 && !got) begin
      @(posedge clk);
      #1;
      cycles++;
      got = rsp_valid;
    end
    if (!got) begin
      check({tag, ".timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, ".latency"}, 32'(cycles), 32'(WAIT + 1));
    check({tag, ".req_ready_resp"}, 32'(req_ready), 32'd0);
    check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, ".rdata"}, rsp_rdata, exp_data);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_rdata"}, rsp_rdata, exp_data);
      check({tag, ".hold_err"}, 32'(rsp_err), 32'(exp_err));
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, ".back_idle"}, 32'(req_ready), 32'd1);
    $display("txn %s we=%0b addr=%08h wdata=%08h size=%0d -> rdata=%08h err=%0b",
             tag, we, addr, wdata, size, rsp_rdata, rsp_err);
  endtask

  initial begin
    logic        r_we_t;
    logic [2:0]  r_size_t;
    logic [31:0] r_addr_t;
    int          sel;
    int          hold;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_size  = 3'd0;
    rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset.req_ready", 32'(req_ready), 32'd1);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_rdata", rsp_rdata, 32'd0);
    check("reset.rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    // Word store/load round trip.
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0, "sw_deadbeef");
    txn(1'b0, 32'h10, 32'd0, 3'b010, 0, "lw_deadbeef");
    // Byte store into a known word, then signed/unsigned/word reads.
    txn(1'b1, 32'h10, 32'h1122_3344, 3'b010, 0, "sw_11223344");
    txn(1'b1, 32'h13, 32'h80, 3'b000, 0, "sb_80");
    txn(1'b0, 32'h13, 32'd0, 3'b000, 0, "lb_13");
    txn(1'b0, 32'h13, 32'd0, 3'b100, 0, "lbu_13");
    txn(1'b0, 32'h10, 32'd0, 3'b010, 0, "lw_after_sb");
    // Misaligned accesses must error and leave memory alone.
    txn(1'b0, 32'h11, 32'd0, 3'b001, 0, "lh_misaligned");
    txn(1'b1, 32'h12, 32'hFFFF_FFFF, 3'b010, 0, "sw_misaligned");
    txn(1'b0, 32'h10, 32'd0, 3'b010, 0, "lw_unchanged");
    // Out of range and illegal store size.
    txn(1'b0, 32'(4 * DEPTH), 32'd0, 3'b010, 0, "lw_out_of_range");
    txn(1'b1, 32'h10, 32'h0000_00AA, 3'b100, 0, "store_size100");
    txn(1'b0, 32'h10, 32'd0, 3'b010, 0, "lw_after_bad_store");
    // Back-pressure in RESP.
    txn(1'b0, 32'h10, 32'd0, 3'b001, 5, "lh_hold5");

    // Reset during BUSY drops the uncommitted store.
    txn(1'b1, 32'h20, 32'd0, 3'b010, 0, "sw_zero_20");
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h1234_5678;
    req_size  = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    $display("txn midrst we=1 addr=00000020 wdata=12345678 size=2 -> aborted by reset");
    txn(1'b0, 32'h20, 32'd0, 3'b010, 0, "lw_after_rst");

    // Fill the random working region with known words.
    for (int w = 0; w < 32; w++) begin
      txn(1'b1, 32'(4 * w), $urandom, 3'b010, 0, "init_sw");
    end

    // Random traffic over the working region plus occasional out-of-range addresses.
    for (int n = 0; n < 150; n++) begin
      r_we_t   = 1'($urandom_range(0, 1));
      r_size_t = 3'($urandom_range(0, 7));
      sel      = int'($urandom_range(0, 9));
      if (sel < 8)       r_addr_t = 32'($urandom_range(0, 127));
      else if (sel == 8) r_addr_t = 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      else               r_addr_t = $urandom | 32'h8000_0000;
      hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
      txn(r_we_t, r_addr_t, $urandom, r_size_t, hold, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
